fp16_operand_sched: RTL



---
 rtl/fp16_operand_sched.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/fp16_operand_sched.sv
// Two-requester round-robin FP16 operand scheduler with bursts of up to BURST words, 2-cycle latency from IDLE, and a registered output.
// Stalls both requesters while the output word is held; optional FP16_SCHED_STATS_EN adds per-requester 16-bit transfer counters.
module fp16_operand_sched #(
   parameter int WIDTH = 16,
   parameter int BURST = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in1_data,
   input  logic             in1_valid,
   output logic             in1_ready,
   input  logic [WIDTH-1:0] in2_data,
   input  logic             in2_valid,
   output logic             in2_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_src,
   output logic             out_valid,
   input  logic             out_ready
`ifdef FP16_SCHED_STATS_EN
   ,
   output logic [15:0]      stat1,
   output logic [15:0]      stat2
`endif
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_GRANT1 = 2'd1,
      S_GRANT2 = 2'd2
   } state_t;

   typedef struct packed {
      logic             src;
      logic [WIDTH-1:0] data;
   } out_word_t;

   localparam logic [7:0] LP_CNT_LAST = 8'(BURST - 1);

   state_t     r_state;
   state_t     w_state_nxt;
   logic       r_last;          // 0 = in1 served last, 1 = in2 served last
   logic       w_last_nxt;
   logic [7:0] r_cnt;
   logic [7:0] w_cnt_nxt;
   out_word_t  r_out;
   logic       r_out_valid;

   logic w_load_en;
   logic w_xfer1;
   logic w_xfer2;

   assign w_load_en = !r_out_valid || out_ready;
   assign in1_ready = w_load_en && (r_state == S_GRANT1);
   assign in2_ready = w_load_en && (r_state == S_GRANT2);
   assign w_xfer1   = in1_valid && in1_ready;
   assign w_xfer2   = in2_valid && in2_ready;

   assign out_data  = r_out.data;
   assign out_src   = r_out.src;
   assign out_valid = r_out_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_last  <= 1'b1;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_last  <= w_last_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_last_nxt  = r_last;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            if (in1_valid && in2_valid) begin
               w_state_nxt = r_last ? S_GRANT1 : S_GRANT2;
            end else if (in1_valid) begin
               w_state_nxt = S_GRANT1;
            end else if (in2_valid) begin
               w_state_nxt = S_GRANT2;
            end
         end
         S_GRANT1: begin
            if (w_xfer1) begin
               if (r_cnt == LP_CNT_LAST) begin
                  w_cnt_nxt   = '0;
                  w_last_nxt  = 1'b0;
                  w_state_nxt = in2_valid ? S_GRANT2 : S_IDLE;
               end else begin
                  w_cnt_nxt = r_cnt + 8'd1;
               end
            end else if (!in1_valid) begin
               w_last_nxt = 1'b0;
               if (in2_valid) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_GRANT2;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         S_GRANT2: begin
            if (w_xfer2) begin
               if (r_cnt == LP_CNT_LAST) begin
                  w_cnt_nxt   = '0;
                  w_last_nxt  = 1'b1;
                  w_state_nxt = in1_valid ? S_GRANT1 : S_IDLE;
               end else begin
                  w_cnt_nxt = r_cnt + 8'd1;
               end
            end else if (!in2_valid) begin
               w_last_nxt = 1'b1;
               if (in1_valid) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_GRANT1;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Output stage: data only moves when the consumer has room, so a held word never changes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out       <= '0;
         r_out_valid <= 1'b0;
      end else if (w_load_en) begin
         if (w_xfer1) begin
            r_out.data  <= in1_data;
            r_out.src   <= 1'b0;
            r_out_valid <= 1'b1;
         end else if (w_xfer2) begin
            r_out.data  <= in2_data;
            r_out.src   <= 1'b1;
            r_out_valid <= 1'b1;
         end else begin
            r_out_valid <= 1'b0;
         end
      end
   end

`ifdef FP16_SCHED_STATS_EN
   logic [15:0] r_stat1;
   logic [15:0] r_stat2;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stat1 <= '0;
         r_stat2 <= '0;
      end else begin
         if (w_xfer1) r_stat1 <= r_stat1 + 16'd1;
         if (w_xfer2) r_stat2 <= r_stat2 + 16'd1;
      end
   end

   assign stat1 = r_stat1;
   assign stat2 = r_stat2;
`endif

endmodule
